// File: rtl/sub_if.sv
// Stream bundle for the fixed-point subtractor: operand side (a/b) and result side (diff).
interface sub_if #(
    parameter int N_BITS_A   = 3,
    parameter int N_BITS_B   = 4,
    parameter int N_BITS_OUT = 6
);
    logic [N_BITS_A-1:0]   a;
    logic [N_BITS_B-1:0]   b;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_BITS_OUT-1:0] diff;
    logic                  overflow;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, diff, overflow, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, diff, overflow, out_valid
    );
endinterface

// File: rtl/sub.sv
// Pipelined signed fixed-point subtractor diff = a - b with binary-point alignment,
// truncate/round quantization, wrap/saturate overflow handling and valid/ready flow control.
module sub #(
    parameter int N_BITS_A   = 3,
    parameter int BIN_PT_A   = 1,
    parameter int N_BITS_B   = 4,
    parameter int BIN_PT_B   = 3,
    parameter int N_BITS_OUT = 6,
    parameter int BIN_PT_OUT = 3,
    parameter int LATENCY    = 2,
    parameter int QUANT      = 0,
    parameter int OVERFLOW   = 0
) (
    input logic clk,
    input logic rst,
    sub_if.slave io
);
    localparam int F_AB  = (BIN_PT_A > BIN_PT_B) ? BIN_PT_A : BIN_PT_B;
    localparam int F     = (F_AB > BIN_PT_OUT) ? F_AB : BIN_PT_OUT;
    localparam int INT_A = N_BITS_A - BIN_PT_A;
    localparam int INT_B = N_BITS_B - BIN_PT_B;
    localparam int I     = ((INT_A > INT_B) ? INT_A : INT_B) + 2;
    localparam int W     = I + F;
    localparam int SH_A  = F - BIN_PT_A;
    localparam int SH_B  = F - BIN_PT_B;
    localparam int DROP  = F - BIN_PT_OUT;
    localparam int CW    = ((W > N_BITS_OUT) ? W : N_BITS_OUT) + 1;

    localparam logic [W-1:0] ONE_W = W'(1);
    // Half an output LSB expressed at full precision; zero when nothing is dropped.
    localparam logic [W-1:0] RND = (QUANT == 1) ? ((ONE_W << DROP) >> 1) : '0;
    localparam logic signed [CW-1:0] MAX_V = CW'((64'sd1 <<< (N_BITS_OUT - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] MIN_V = ~MAX_V;

    logic signed [W-1:0]  a_ext;
    logic signed [W-1:0]  b_ext;
    logic signed [W-1:0]  d_full;
    logic signed [W-1:0]  d_rnd;
    logic signed [W-1:0]  d_quant;
    logic signed [CW-1:0] q_ext;
    logic [N_BITS_OUT-1:0] res_diff;
    logic                  res_ovf;

    always_comb begin
        a_ext   = W'($signed(io.a)) <<< SH_A;
        b_ext   = W'($signed(io.b)) <<< SH_B;
        d_full  = a_ext - b_ext;
        d_rnd   = d_full + RND;
        d_quant = d_rnd >>> DROP;
        q_ext   = CW'(d_quant);
        res_ovf = (q_ext > MAX_V) || (q_ext < MIN_V);
        if (res_ovf && (OVERFLOW == 1)) begin
            res_diff = (q_ext > MAX_V) ? MAX_V[N_BITS_OUT-1:0] : MIN_V[N_BITS_OUT-1:0];
        end else begin
            res_diff = q_ext[N_BITS_OUT-1:0];
        end
    end

    logic [N_BITS_OUT-1:0] stg_diff_q [LATENCY];
    logic [N_BITS_OUT-1:0] stg_diff_d [LATENCY];
    logic                  stg_ovf_q  [LATENCY];
    logic                  stg_ovf_d  [LATENCY];
    logic                  stg_vld_q  [LATENCY];
    logic                  stg_vld_d  [LATENCY];
    logic                  stall;

    assign stall        = stg_vld_q[LATENCY-1] & ~io.out_ready;
    assign io.in_ready  = ~rst & ~stall;
    assign io.diff      = stg_diff_q[LATENCY-1];
    assign io.overflow  = stg_ovf_q[LATENCY-1];
    assign io.out_valid = stg_vld_q[LATENCY-1];

    // Whole pipeline advances together or freezes together; bubbles travel as vld=0.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            stg_diff_d[i] = stg_diff_q[i];
            stg_ovf_d[i]  = stg_ovf_q[i];
            stg_vld_d[i]  = stg_vld_q[i];
        end
        if (!stall) begin
            stg_diff_d[0] = res_diff;
            stg_ovf_d[0]  = res_ovf;
            stg_vld_d[0]  = io.in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                stg_diff_d[i] = stg_diff_q[i-1];
                stg_ovf_d[i]  = stg_ovf_q[i-1];
                stg_vld_d[i]  = stg_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_diff_q[i] <= '0;
                stg_ovf_q[i]  <= 1'b0;
                stg_vld_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_diff_q[i] <= stg_diff_d[i];
                stg_ovf_q[i]  <= stg_ovf_d[i];
                stg_vld_q[i]  <= stg_vld_d[i];
            end
        end
    end
endmodule

// File: tb/tb_sub.sv
// Self-checking bench: four differently configured subtractors share one stimulus stream and
// are compared against an integer-arithmetic model plus a queue of in-flight samples.
module tb_sub;
    localparam int LAT = 2;
    localparam int NOUT [4] = '{6, 4, 3, 4};
    localparam int BPO  [4] = '{3, 3, 1, 3};
    localparam int QU   [4] = '{0, 0, 1, 0};
    localparam int OV   [4] = '{0, 1, 0, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       out_ready;

    always #5 clk = ~clk;

    sub_if #(.N_BITS_A(3), .N_BITS_B(4), .N_BITS_OUT(6)) io0 ();
    sub_if #(.N_BITS_A(3), .N_BITS_B(4), .N_BITS_OUT(4)) io1 ();
    sub_if #(.N_BITS_A(3), .N_BITS_B(4), .N_BITS_OUT(3)) io2 ();
    sub_if #(.N_BITS_A(3), .N_BITS_B(4), .N_BITS_OUT(4)) io3 ();

    assign io0.a = a; assign io0.b = b; assign io0.in_valid = in_valid; assign io0.out_ready = out_ready;
    assign io1.a = a; assign io1.b = b; assign io1.in_valid = in_valid; assign io1.out_ready = out_ready;
    assign io2.a = a; assign io2.b = b; assign io2.in_valid = in_valid; assign io2.out_ready = out_ready;
    assign io3.a = a; assign io3.b = b; assign io3.in_valid = in_valid; assign io3.out_ready = out_ready;

    sub u0 (.clk(clk), .rst(rst), .io(io0));
    sub #(.N_BITS_OUT(4), .BIN_PT_OUT(3), .OVERFLOW(1)) u1 (.clk(clk), .rst(rst), .io(io1));
    sub #(.N_BITS_OUT(3), .BIN_PT_OUT(1), .QUANT(1))    u2 (.clk(clk), .rst(rst), .io(io2));
    sub #(.N_BITS_OUT(4), .BIN_PT_OUT(3))               u3 (.clk(clk), .rst(rst), .io(io3));

    logic [15:0] dd [4];
    logic        oo [4];
    logic        rr [4];
    logic        vv [4];

    assign dd[0] = 16'(io0.diff); assign oo[0] = io0.overflow; assign rr[0] = io0.in_ready; assign vv[0] = io0.out_valid;
    assign dd[1] = 16'(io1.diff); assign oo[1] = io1.overflow; assign rr[1] = io1.in_ready; assign vv[1] = io1.out_valid;
    assign dd[2] = 16'(io2.diff); assign oo[2] = io2.overflow; assign rr[2] = io2.in_ready; assign vv[2] = io2.out_valid;
    assign dd[3] = 16'(io3.diff); assign oo[3] = io3.overflow; assign rr[3] = io3.in_ready; assign vv[3] = io3.out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] qa   [$];
    logic [3:0] qb   [$];
    int         qage [$];

    // Exact rational arithmetic in units of 2^-F, then floor/round and range handling.
    function automatic void model(input logic [2:0] av, input logic [3:0] bv, input int k,
                                  output logic [15:0] d, output logic o);
        int as_, bs_, f, v, drop, q, maxv, minv;
        as_  = av[2] ? int'(av) - 8 : int'(av);
        bs_  = bv[3] ? int'(bv) - 16 : int'(bv);
        f    = (BPO[k] > 3) ? BPO[k] : 3;
        v    = as_ * (1 << (f - 1)) - bs_ * (1 << (f - 3));
        drop = f - BPO[k];
        if (QU[k] == 1 && drop > 0) v = v + (1 << (drop - 1));
        q    = v >>> drop;
        maxv = (1 << (NOUT[k] - 1)) - 1;
        minv = -maxv - 1;
        o    = (q > maxv) || (q < minv);
        if (o && OV[k] == 1) q = (q > maxv) ? maxv : minv;
        d    = 16'(q & ((1 << NOUT[k]) - 1));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic cycle(input logic r, input logic [2:0] av, input logic [3:0] bv,
                         input logic iv, input logic orr);
        logic        exp_ov, exp_ir, eo;
        logic [15:0] ed;
        @(negedge clk);
        rst = r; a = av; b = bv; in_valid = iv; out_ready = orr;
        #1;
        exp_ov = (qage.size() > 0) && (qage[0] == LAT);
        exp_ir = !r && !(exp_ov && !orr);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("in_ready[%0d]", k), 16'(rr[k]), 16'(exp_ir));
            chk($sformatf("out_valid[%0d]", k), 16'(vv[k]), 16'(exp_ov));
            if (exp_ov) begin
                model(qa[0], qb[0], k, ed, eo);
                chk($sformatf("diff[%0d]", k), dd[k], ed);
                chk($sformatf("overflow[%0d]", k), 16'(oo[k]), 16'(eo));
            end
        end
        if (r) begin
            qa.delete(); qb.delete(); qage.delete();
        end else if (exp_ir) begin
            if (exp_ov) begin
                void'(qa.pop_front()); void'(qb.pop_front()); void'(qage.pop_front());
            end
            for (int i = 0; i < qage.size(); i++) qage[i] = qage[i] + 1;
            if (iv) begin
                qa.push_back(av); qb.push_back(bv); qage.push_back(1);
            end
        end
    endtask

    task automatic chk_cleared(input string tag);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_valid[%0d]", tag, k), 16'(vv[k]), 16'h0);
            chk($sformatf("%s_diff[%0d]", tag, k), dd[k], 16'h0);
            chk($sformatf("%s_ovf[%0d]", tag, k), 16'(oo[k]), 16'h0);
        end
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(1, 3'b000, 4'b0000, 1, 1);
        cycle(1, 3'b000, 4'b0000, 1, 1);
        chk_cleared("reset");

        // Directed vectors back-to-back, then extreme operand pairs.
        cycle(0, 3'b000, 4'b0001, 1, 1);
        cycle(0, 3'b011, 4'b1110, 1, 1);
        cycle(0, 3'b110, 4'b0100, 1, 1);
        cycle(0, 3'b100, 4'b0111, 1, 1);
        cycle(0, 3'b011, 4'b1000, 1, 1);
        cycle(0, 3'b011, 4'b0111, 1, 1);
        cycle(0, 3'b100, 4'b1000, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 3'b000, 4'b0000, 0, 1);

        // Bubbles are preserved.
        cycle(0, 3'b001, 4'b0011, 1, 1);
        cycle(0, 3'b111, 4'b1111, 0, 1);
        cycle(0, 3'b010, 4'b1001, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 3'b000, 4'b0000, 0, 1);

        // Backpressure for 5 cycles, new input offered during the stall and on release.
        cycle(0, 3'b001, 4'b0101, 1, 1);
        cycle(0, 3'b101, 4'b1100, 1, 1);
        cycle(0, 3'b011, 4'b1110, 1, 1);
        for (int i = 0; i < 5; i++) cycle(0, 3'b110, 4'b0110, 1, 0);
        cycle(0, 3'b010, 4'b0010, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 3'b000, 4'b0000, 0, 1);

        // Reset with the pipeline full and stalled.
        cycle(0, 3'b011, 4'b1000, 1, 1);
        cycle(0, 3'b100, 4'b0111, 1, 1);
        cycle(0, 3'b001, 4'b0001, 1, 0);
        cycle(0, 3'b001, 4'b0001, 1, 0);
        cycle(1, 3'b001, 4'b0001, 1, 0);
        chk_cleared("midrst");
        for (int i = 0; i < 5; i++) cycle(0, 3'b000, 4'b0000, 0, 1);

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ab;
            ab = 7'($urandom);
            cycle(($urandom_range(0, 49) == 0), ab[6:4], ab[3:0],
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 6; i++) cycle(0, 3'b000, 4'b0000, 0, 1);
        chk("drained", 16'(qage.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
